// File: rtl/bcd_sseg_if.sv
// rtl/bcd_sseg_if.sv - BCD result input and seven-segment pin bundle for bcd_sseg_scan
interface bcd_sseg_if;
  logic [15:0] bcd;
  logic        rdy;
  logic        en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  modport master (
    output bcd, rdy, en,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  bcd, rdy, en,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/bcd_sseg_scan.sv
// rtl/bcd_sseg_scan.sv - 4-digit common-anode scan driver for a packed BCD result
// Latches the converter result on a rdy rising edge, then multiplexes digits with blanking.
module bcd_sseg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  bcd_sseg_if.slave  bus
);

  localparam int            PW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

  logic [15:0]   r_disp_q;
  logic          r_rdy_d;
  logic [PW-1:0] r_prescaler;
  logic [1:0]    r_idx;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_frame_tick;

  logic          w_wrap;
  logic          w_capture;
  logic [3:0]    w_nib;
  logic          w_t_zero;
  logic          w_h_zero;
  logic          w_te_zero;
  logic          w_blank;
  logic [6:0]    w_seg_dec;
  logic [6:0]    w_seg_next;
  logic [3:0]    w_an_next;

  assign w_wrap    = (r_prescaler == PRE_MAX);
  // Only a true rising edge captures; a rdy left high from the previous conversion is ignored.
  assign w_capture = bus.rdy && !r_rdy_d;

  assign w_nib     = r_disp_q[{r_idx, 2'b00} +: 4];
  assign w_t_zero  = (r_disp_q[15:12] == 4'd0);
  assign w_h_zero  = (r_disp_q[11:8]  == 4'd0);
  assign w_te_zero = (r_disp_q[7:4]   == 4'd0);

  always_comb begin
    w_blank = 1'b0;
    if (BLANK_LZ) begin
      case (r_idx)
        2'd3:    w_blank = w_t_zero;
        2'd2:    w_blank = w_t_zero && w_h_zero;
        2'd1:    w_blank = w_t_zero && w_h_zero && w_te_zero;
        default: w_blank = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_seg_dec = 7'h3F;
    case (w_nib)
      4'd0:    w_seg_dec = 7'h40;
      4'd1:    w_seg_dec = 7'h79;
      4'd2:    w_seg_dec = 7'h24;
      4'd3:    w_seg_dec = 7'h30;
      4'd4:    w_seg_dec = 7'h19;
      4'd5:    w_seg_dec = 7'h12;
      4'd6:    w_seg_dec = 7'h02;
      4'd7:    w_seg_dec = 7'h78;
      4'd8:    w_seg_dec = 7'h00;
      4'd9:    w_seg_dec = 7'h10;
      default: w_seg_dec = 7'h3F;
    endcase
  end

  always_comb begin
    w_seg_next = 7'h7F;
    w_an_next  = 4'hF;
    if (bus.en) begin
      w_an_next  = ~(4'b0001 << r_idx);
      w_seg_next = w_blank ? 7'h7F : w_seg_dec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp_q     <= 16'h0000;
      r_rdy_d      <= 1'b0;
      r_prescaler  <= '0;
      r_idx        <= 2'd0;
      r_seg        <= 7'h7F;
      r_an         <= 4'hF;
      r_frame_tick <= 1'b0;
    end else begin
      r_rdy_d <= bus.rdy;
      if (w_capture) begin
        r_disp_q <= bus.bcd;
      end
      if (w_wrap) begin
        r_prescaler <= '0;
        r_idx       <= r_idx + 2'd1;
      end else begin
        r_prescaler <= r_prescaler + 1'b1;
      end
      r_frame_tick <= w_wrap && (r_idx == 2'd3);
      r_seg        <= w_seg_next;
      r_an         <= w_an_next;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.frame_tick = r_frame_tick;
  assign bus.dp         = 1'b1;

endmodule

// File: doc/bcd_sseg_scan.md
Name: bcd_sseg_scan

Overview:
- Drives the 4-digit common-anode seven-segment display from the 16-bit packed BCD result of the binary-to-BCD converter.
- Captures a stable result only when the converter signals completion, then time-multiplexes the four digits with a programmable refresh prescaler.
- Applies leading-zero blanking and shows a dash for any non-decimal nibble.
- Sits directly downstream of the BCD converter and drives the board pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range 1..2^20.
- BLANK_LZ, 1, 1 = blank leading zeros on thousands/hundreds/tens; 0 = show all four digits.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high.
- bcd  input  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- rdy  input  1  converter result valid; may be high for one cycle with non-final bcd at the start of a conversion.
- en  input  1  display enable; 0 turns all digits dark.
- seg  output  7  active-low segments {g,f,e,d,c,b,a}.
- dp  output  1  active-low decimal point; constant 1 (off).
- an  output  4  active-low digit enables; an[0] = ones, an[3] = thousands.
- frame_tick  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Behaviour:
- Interface (already decided): reset reset, asynchronous, active-high; clock clk.
- Reset values:
  - an=4'b1111, seg=7'h7F, dp=1, frame_tick=0.
  - Internal: disp_q=0, rdy_d=0, prescaler=0, idx=0.
- Capture:
  - rdy_d <= rdy every cycle.
  - When rdy=1 and rdy_d=0 (rising edge), disp_q <= bcd on that edge.
  - A level-high rdy without a rising edge never recaptures. This rejects the one-cycle stale-high rdy at conversion start.
  - disp_q holds its value while rdy is low.
- Prescaler:
  - Counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it wraps to 0 and idx <= idx+1 (mod 4).
  - Width is ceil(log2(REFRESH_DIV)), minimum 1 bit.
  - With REFRESH_DIV=1, idx advances every cycle.
- frame_tick: registered. Set to 1 on the edge where the prescaler wraps and idx==3; otherwise 0.
- Outputs: registered every cycle from current idx and disp_q.
  - an <= ~(1<<idx); seg <= decode(digit[idx]).
  - Latency: 1 cycle from an idx change to seg/an; 2 cycles from a sampled rdy rising edge to seg on the active digit.
- Decode (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Nibbles A-F = 3F (dash, segment g only).
  - Blank = 7F.
- Leading-zero blanking (BLANK_LZ=1):
  - Thousands blanked if T==0.
  - Hundreds blanked if T==0 and H==0.
  - Tens blanked if T, H and Te are all 0.
  - Ones never blanked, so value 0 shows a single "0".
  - Blanked digit: seg=7F, its an bit is still driven low.
  - A non-zero invalid nibble (A-F) counts as non-zero and stops blanking.
- Enable: en=0 forces an=1111 and seg=7F on the next edge. Prescaler, idx, capture and frame_tick keep running. en=1 resumes at the current idx with no reset of the scan.
- Simultaneous events: a capture on the same edge as an idx advance is visible on the new digit one cycle later. No priority conflict exists.
- Reset mid-operation: all state and outputs return to reset values immediately (asynchronous). The previously captured value is lost; the display shows 0 after the next rdy rising edge.

Test Plan (REFRESH_DIV=4, BLANK_LZ=1 unless stated):
1. Assert reset mid-frame -> an=1111, seg=7F, dp=1 immediately. After release and a rdy rising edge with bcd=0000 -> ones shows seg=40 on an=1110; other digits show seg=7F.
2. rdy rising edge with bcd=16'h1234 -> each digit held 4 cycles: an=1110/seg=19, an=1101/30, an=1011/24, an=0111/79. frame_tick pulses once every 16 cycles.
3. Hold rdy=1 from the previous conversion, change bcd to 0000, then drive rdy=0 for 20 cycles while bcd changes, then rdy rising edge with bcd=16'h0056:
   - Digits show 1234 throughout the rdy-high and rdy-low phases.
   - Afterwards: thousands and hundreds seg=7F, tens=12, ones=02.
4. bcd=16'h0A05 captured -> thousands 7F, hundreds 3F (dash), tens 40 (not blanked), ones 12. With BLANK_LZ=0 -> thousands shows 40.
5. en=0 for 10 cycles -> an=1111, seg=7F one cycle after en falls, and frame_tick keeps pulsing. en=1 -> an resumes at the idx the counter reached, with correct seg.
6. REFRESH_DIV=1 with bcd=16'h9999 -> an rotates every cycle, seg=10 constant, frame_tick every 4 cycles.
